// File: rtl/stage1_ctrl_pkg.sv
// Shared constants for the Stage 1 control sequencer: state encoding,
// ALU operation / operand-select codes and the saturating increment helper.
package stage1_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOADPC   = 3'd1,
        ST_FETCH    = 3'd2,
        ST_COMPARE  = 3'd3,
        ST_REDIRECT = 3'd4
    } state_t;

    localparam logic [3:0]  ALU_ADD   = 4'h0;
    localparam logic [1:0]  SRC_A_EXT = 2'd0;
    localparam logic [1:0]  SRC_A_PC  = 2'd1;
    localparam logic [1:0]  SRC_B_EXT = 2'd0;
    localparam logic [1:0]  SRC_B_TWO = 2'd2;
    localparam logic [15:0] PC_STEP   = 16'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stage1_ctrl_sat_counter.sv
// 16-bit counter that sticks at 0xFFFF instead of wrapping.
module sat_counter16
    import stage1_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    output logic [15:0] count
);

    logic [15:0] count_r;

    // count register, held at the top value once reached
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 16'd0;
        end else if (inc) begin
            count_r <= sat_inc16(count_r);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/stage1_ctrl.sv
// Stage 1 control sequencer: drives PC/ALU selects and enables for load,
// sequential fetch, conditional-branch compare and PC redirect.
module stage1_ctrl
    import stage1_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        load_pc,
    input  logic        halt,
    input  logic        stall,
    input  logic        br_req,
    input  logic        br_jump,
    input  logic [3:0]  br_op,
    input  logic [15:0] br_target,
    input  logic        isTrue,
    output logic        WEpc,
    output logic        inputPC,
    output logic        normOrBranch,
    output logic [1:0]  ALUsrca,
    output logic [1:0]  ALUsrcb,
    output logic [3:0]  ALUOp,
    output logic [15:0] NOB1,
    output logic        fetch_valid,
    output logic        flush,
    output logic [15:0] taken_count
);

    state_t      state_r;
    state_t      state_s;
    logic [15:0] nob1_r;
    logic [3:0]  op_r;
    logic        jump_r;
    logic        accept_s;
    logic        taken_s;

    // A branch is accepted only in an unstalled FETCH cycle that is not halting
    assign accept_s = (state_r == ST_FETCH) && !halt && br_req && !stall;
    assign taken_s  = (state_r == ST_REDIRECT);

    // next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_pc) begin
                    state_s = ST_LOADPC;
                end else if (start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOADPC:   state_s = ST_IDLE;
            ST_FETCH: begin
                if (halt) begin
                    state_s = ST_IDLE;
                end else if (br_req && !stall) begin
                    state_s = br_jump ? ST_REDIRECT : ST_COMPARE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_COMPARE: begin
                if (jump_r || isTrue) begin
                    state_s = ST_REDIRECT;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_REDIRECT: state_s = ST_FETCH;
            default:     state_s = ST_IDLE;
        endcase
    end

    // output decode; reset suppresses any PC write in the cycle it is applied
    always_comb begin
        WEpc         = 1'b0;
        inputPC      = 1'b0;
        normOrBranch = 1'b0;
        ALUsrca      = SRC_A_EXT;
        ALUsrcb      = SRC_B_EXT;
        ALUOp        = ALU_ADD;
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                WEpc = 1'b0;
            end
            ST_LOADPC: begin
                WEpc    = !reset;
                inputPC = 1'b1;
            end
            ST_FETCH: begin
                WEpc        = !stall && !reset;
                ALUsrca     = SRC_A_PC;
                ALUsrcb     = SRC_B_TWO;
                ALUOp       = ALU_ADD;
                fetch_valid = 1'b1;
            end
            ST_COMPARE: begin
                ALUOp = op_r;
            end
            ST_REDIRECT: begin
                WEpc         = !reset;
                normOrBranch = 1'b1;
                flush        = 1'b1;
            end
            default: begin
                WEpc = 1'b0;
            end
        endcase
    end

    // state and latched branch request
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r <= ST_IDLE;
            nob1_r  <= 16'd0;
            op_r    <= 4'd0;
            jump_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                nob1_r <= br_target;
                op_r   <= br_op;
                jump_r <= br_jump;
            end else begin
                nob1_r <= nob1_r;
                op_r   <= op_r;
                jump_r <= jump_r;
            end
        end
    end

    sat_counter16 u_cnt (
        .clk   (CLK),
        .reset (reset),
        .inc   (taken_s),
        .count (taken_count)
    );

    assign NOB1 = nob1_r;

endmodule

// File: tb/tb_stage1_ctrl.sv
// Self-checking bench for stage1_ctrl: directed vector table, saturation
// sequence, then randomized stimulus against a behavioural model.
module tb_stage1_ctrl;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, load_pc = 1'b0, halt = 1'b0, stall = 1'b0;
    logic        br_req = 1'b0, br_jump = 1'b0, isTrue = 1'b0;
    logic [3:0]  br_op = 4'h0;
    logic [15:0] br_target = 16'h0;
    logic        WEpc, inputPC, normOrBranch, fetch_valid, flush;
    logic [1:0]  ALUsrca, ALUsrcb;
    logic [3:0]  ALUOp;
    logic [15:0] NOB1, taken_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    stage1_ctrl dut (
        .CLK(CLK), .reset(reset), .start(start), .load_pc(load_pc), .halt(halt),
        .stall(stall), .br_req(br_req), .br_jump(br_jump), .br_op(br_op),
        .br_target(br_target), .isTrue(isTrue), .WEpc(WEpc), .inputPC(inputPC),
        .normOrBranch(normOrBranch), .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb),
        .ALUOp(ALUOp), .NOB1(NOB1), .fetch_valid(fetch_valid), .flush(flush),
        .taken_count(taken_count)
    );

    // Expected output word: {WEpc,inputPC,normOrBranch,srca,srcb,op,fetch_valid,flush,NOB1,count}
    typedef struct packed {
        logic        rst, st, ld, hl, stl, brq, jmp;
        logic [3:0]  op;
        logic [15:0] tgt;
        logic        ist;
        logic [44:0] exp;
    } vec_t;

    function automatic logic [44:0] pack(input logic we, ipc, nob, input logic [1:0] sa, sb,
                                         input logic [3:0] op, input logic fv, fl,
                                         input logic [15:0] nob1, cnt);
        return {we, ipc, nob, sa, sb, op, fv, fl, nob1, cnt};
    endfunction

    function automatic logic [44:0] e_idle(input logic [15:0] nob1, cnt);
        return pack(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0, nob1, cnt);
    endfunction
    function automatic logic [44:0] e_load(input logic we, input logic [15:0] nob1, cnt);
        return pack(we, 1'b1, 1'b0, 2'd0, 2'd0, 4'h0, 1'b0, 1'b0, nob1, cnt);
    endfunction
    function automatic logic [44:0] e_fetch(input logic we, input logic [15:0] nob1, cnt);
        return pack(we, 1'b0, 1'b0, 2'd1, 2'd2, 4'h0, 1'b1, 1'b0, nob1, cnt);
    endfunction
    function automatic logic [44:0] e_cmp(input logic [3:0] op, input logic [15:0] nob1, cnt);
        return pack(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, op, 1'b0, 1'b0, nob1, cnt);
    endfunction
    function automatic logic [44:0] e_redir(input logic we, input logic [15:0] nob1, cnt);
        return pack(we, 1'b0, 1'b1, 2'd0, 2'd0, 4'h0, 1'b0, 1'b1, nob1, cnt);
    endfunction

    function automatic vec_t mk(input logic rst, st, ld, hl, stl, brq, jmp,
                                input logic [3:0] op, input logic [15:0] tgt,
                                input logic ist, input logic [44:0] exp);
        vec_t v;
        v.rst = rst; v.st = st; v.ld = ld; v.hl = hl; v.stl = stl; v.brq = brq;
        v.jmp = jmp; v.op = op; v.tgt = tgt; v.ist = ist; v.exp = exp;
        return v;
    endfunction

    // Drive one cycle's inputs at the falling edge, compare shortly after
    task automatic step(input string name, input int idx, input vec_t v);
        logic [44:0] got;
        @(negedge CLK);
        reset = v.rst; start = v.st; load_pc = v.ld; halt = v.hl; stall = v.stl;
        br_req = v.brq; br_jump = v.jmp; br_op = v.op; br_target = v.tgt; isTrue = v.ist;
        #1;
        got = {WEpc, inputPC, normOrBranch, ALUsrca, ALUsrcb, ALUOp, fetch_valid, flush,
               NOB1, taken_count};
        n_checks++;
        if (got !== v.exp) begin
            n_fail++;
            $display("FAIL %s %0d: outputs got %h expected %h", name, idx, got, v.exp);
        end
    endtask

    localparam int M_IDLE = 0, M_LOAD = 1, M_FETCH = 2, M_CMP = 3, M_REDIR = 4;

    vec_t tbl[29];
    vec_t sat[6];

    initial begin
        tbl[0]  = mk(1,0,0,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h0000,16'd0));
        tbl[1]  = mk(0,0,1,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h0000,16'd0));
        tbl[2]  = mk(0,0,0,0,0,0,0,4'h0,16'h0000,0, e_load(1'b1,16'h0000,16'd0));
        tbl[3]  = mk(0,1,0,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h0000,16'd0));
        for (int i = 4; i <= 6; i++)
            tbl[i] = mk(0,0,0,0,0,0,0,4'h0,16'h0000,0, e_fetch(1'b1,16'h0000,16'd0));
        for (int i = 7; i <= 8; i++)
            tbl[i] = mk(0,0,0,0,1,0,0,4'h0,16'h0000,0, e_fetch(1'b0,16'h0000,16'd0));
        tbl[9]  = mk(0,0,0,0,0,1,0,4'h5,16'h0040,0, e_fetch(1'b1,16'h0000,16'd0));
        tbl[10] = mk(0,0,0,0,0,0,0,4'h0,16'h0000,1, e_cmp(4'h5,16'h0040,16'd0));
        tbl[11] = mk(0,0,0,0,0,0,0,4'h0,16'h0000,0, e_redir(1'b1,16'h0040,16'd0));
        tbl[12] = mk(0,0,0,0,0,1,0,4'h5,16'h0040,0, e_fetch(1'b1,16'h0040,16'd1));
        tbl[13] = mk(0,0,0,1,0,1,1,4'h9,16'h7777,0, e_cmp(4'h5,16'h0040,16'd1));
        for (int i = 14; i <= 16; i++)
            tbl[i] = mk(0,0,0,0,1,1,1,4'h3,16'h1234,0, e_fetch(1'b0,16'h0040,16'd1));
        tbl[17] = mk(0,0,0,0,0,1,1,4'h3,16'h1234,0, e_fetch(1'b1,16'h0040,16'd1));
        tbl[18] = mk(0,0,0,1,0,1,0,4'h0,16'h2222,0, e_redir(1'b1,16'h1234,16'd1));
        tbl[19] = mk(0,0,0,1,1,0,0,4'h0,16'h0000,0, e_fetch(1'b0,16'h1234,16'd2));
        tbl[20] = mk(0,0,0,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h1234,16'd2));
        tbl[21] = mk(0,1,1,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h1234,16'd2));
        tbl[22] = mk(0,0,0,0,0,0,0,4'h0,16'h0000,0, e_load(1'b1,16'h1234,16'd2));
        tbl[23] = mk(0,1,0,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h1234,16'd2));
        tbl[24] = mk(0,0,0,1,0,1,1,4'h0,16'h5555,0, e_fetch(1'b1,16'h1234,16'd2));
        tbl[25] = mk(0,1,0,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h1234,16'd2));
        tbl[26] = mk(0,0,0,0,0,1,1,4'h0,16'hBEEF,0, e_fetch(1'b1,16'h1234,16'd2));
        tbl[27] = mk(1,0,0,0,0,0,0,4'h0,16'h0000,0, e_redir(1'b0,16'hBEEF,16'd2));
        tbl[28] = mk(0,0,0,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h0000,16'd0));

        sat[0] = mk(0,1,0,0,0,0,0,4'h0,16'h0000,0, e_idle(16'h0000,16'd0));
        sat[1] = mk(0,0,0,0,0,1,1,4'h0,16'h00A0,0, e_fetch(1'b1,16'h0000,16'hFFFE));
        sat[2] = mk(0,0,0,0,0,0,0,4'h0,16'h0000,0, e_redir(1'b1,16'h00A0,16'hFFFE));
        sat[3] = mk(0,0,0,0,1,1,1,4'h0,16'h00A2,0, e_fetch(1'b0,16'h00A0,16'hFFFF));
        sat[4] = mk(0,0,0,0,0,1,1,4'h0,16'h00A2,0, e_fetch(1'b1,16'h00A0,16'hFFFF));
        sat[5] = mk(0,0,0,0,0,0,0,4'h0,16'h0000,0, e_redir(1'b1,16'h00A2,16'hFFFF));

        repeat (2) @(posedge CLK);

        for (int i = 0; i < 29; i++) step("table row", i, tbl[i]);

        // preload the taken counter just below its ceiling while still in IDLE
        step("saturation step", 0, sat[0]);
        force dut.u_cnt.count_r = 16'hFFFE;
        #1;
        release dut.u_cnt.count_r;
        for (int i = 1; i < 6; i++) step("saturation step", i, sat[i]);
        step("saturation step", 6, mk(0,0,0,0,0,0,0,4'h0,16'h0000,0,
                                       e_fetch(1'b1,16'h00A2,16'hFFFF)));

        // randomized run against a behavioural model, starting from reset
        begin
            int          mode;
            logic [15:0] m_nob1, m_cnt;
            logic [3:0]  m_op;
            vec_t        v;
            logic [44:0] e;
            mode = M_IDLE; m_nob1 = 16'h0; m_cnt = 16'h0; m_op = 4'h0;
            for (int c = 0; c < 1500; c++) begin
                v.rst = (c == 0) || ($urandom_range(0, 49) == 0);
                v.st  = ($urandom_range(0, 3) == 0);
                v.ld  = ($urandom_range(0, 7) == 0);
                v.hl  = ($urandom_range(0, 15) == 0);
                v.stl = ($urandom_range(0, 2) == 0);
                v.brq = ($urandom_range(0, 2) == 0);
                v.jmp = $urandom_range(0, 1);
                v.op  = 4'($urandom);
                v.tgt = 16'($urandom);
                v.ist = $urandom_range(0, 1);
                if (c == 0) begin
                    e = 45'h0;
                end else if (mode == M_LOAD) begin
                    e = e_load(!v.rst, m_nob1, m_cnt);
                end else if (mode == M_FETCH) begin
                    e = e_fetch(!v.stl && !v.rst, m_nob1, m_cnt);
                end else if (mode == M_CMP) begin
                    e = e_cmp(m_op, m_nob1, m_cnt);
                end else if (mode == M_REDIR) begin
                    e = e_redir(!v.rst, m_nob1, m_cnt);
                end else begin
                    e = e_idle(m_nob1, m_cnt);
                end
                v.exp = e;
                if (c == 0) begin
                    // the bench's model has no history yet; just apply reset
                    @(negedge CLK);
                    reset = 1'b1;
                end else begin
                    step("random cycle", c, v);
                end
                if (v.rst) begin
                    mode = M_IDLE; m_nob1 = 16'h0; m_cnt = 16'h0; m_op = 4'h0;
                end else if (mode == M_IDLE) begin
                    mode = v.ld ? M_LOAD : (v.st ? M_FETCH : M_IDLE);
                end else if (mode == M_LOAD) begin
                    mode = M_IDLE;
                end else if (mode == M_FETCH) begin
                    if (v.hl) begin
                        mode = M_IDLE;
                    end else if (v.brq && !v.stl) begin
                        m_nob1 = v.tgt;
                        m_op   = v.op;
                        mode   = v.jmp ? M_REDIR : M_CMP;
                    end
                end else if (mode == M_CMP) begin
                    mode = v.ist ? M_REDIR : M_FETCH;
                end else begin
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    mode = M_FETCH;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage1_ctrl.md
Name: stage1_ctrl

Overview:
- Control sequencer that drives the Stage 1 datapath's (PC register, ALU, PC/ALU source muxes) select and enable inputs.
- Consumes the datapath's isTrue flag and supplies the branch target on the NOB1 path.
- Sequences PC load, sequential fetch (PC+2), conditional-branch compare and PC redirect.
- Hands out fetch slots to the downstream stage under a stall signal.

Parameters:
- ALU_ADD, 4'h0, ALUOp encoding for 16-bit add used for PC+2.
- SRC_A_EXT, 2'd0, ALUsrca select for the external operand A (ALUsrcA0).
- SRC_A_PC, 2'd1, ALUsrca select for PCout.
- SRC_B_EXT, 2'd0, ALUsrcb select for the external operand B (ALUsrcB0).
- SRC_B_TWO, 2'd2, ALUsrcb select for constant 2.

Ports:
- CLK  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  leave IDLE and begin fetching
- load_pc  input  1  in IDLE: write inputPC1 into PC
- halt  input  1  return to IDLE from FETCH
- stall  input  1  downstream not ready; fetch slot not consumed
- br_req  input  1  branch issued by a later stage (valid with br_*)
- br_jump  input  1  unconditional branch (skip compare)
- br_op  input  4  ALUOp for the branch compare
- br_target  input  16  branch destination
- isTrue  input  1  ALU compare result from the datapath
- WEpc  output  1  PC write enable
- inputPC  output  1  0: ALU result to PC, 1: inputPC1 to PC
- normOrBranch  output  1  0: normal path, 1: NOB1 to PC
- ALUsrca  output  2  ALU A select
- ALUsrcb  output  2  ALU B select
- ALUOp  output  4  ALU operation
- NOB1  output  16  latched branch target
- fetch_valid  output  1  current PC is a valid fetch address
- flush  output  1  one-cycle pulse: discard younger fetches
- taken_count  output  16  saturating count of taken redirects

Behaviour:
- States: IDLE, LOADPC, FETCH, COMPARE, REDIRECT. Encoding is 3 bits.
- Reset: state IDLE, NOB1 = 0, taken_count = 0, latched op/jump = 0.
- Outputs in IDLE: all 0, ALUsrca = SRC_A_EXT, ALUsrcb = SRC_B_EXT, ALUOp = ALU_ADD.
- Reset mid-operation aborts any state, with no PC write in that cycle.
- Outputs are a decode of state and latched registers only. The one exception is WEpc in FETCH, which also depends on stall.
- IDLE transitions:
  - load_pc -> LOADPC.
  - else start -> FETCH.
  - load_pc has priority over start.
- LOADPC: inputPC = 1, normOrBranch = 0, WEpc = 1 for exactly one cycle, then IDLE.
- FETCH outputs: ALUsrca = SRC_A_PC, ALUsrcb = SRC_B_TWO, ALUOp = ALU_ADD, fetch_valid = 1, WEpc = !stall. PC advances by 2 each unstalled cycle; 16-bit wrap from 0xFFFE to 0x0000 is legal.
- FETCH transitions, priority halt > br_req > stay:
  - halt: -> IDLE; WEpc still = !stall that cycle.
  - br_req && !stall: latch br_target into NOB1, latch br_op and br_jump. Then br_jump -> REDIRECT, else -> COMPARE.
  - br_req while stall = 1: ignored. The requester must hold br_req and br_* until a non-stalled cycle.
- COMPARE: one cycle. ALUsrca = SRC_A_EXT, ALUsrcb = SRC_B_EXT, ALUOp = latched op, WEpc = 0, fetch_valid = 0. isTrue is sampled at the clock edge ending the cycle: 1 -> REDIRECT, 0 -> FETCH.
- REDIRECT: one cycle. normOrBranch = 1, inputPC = 0, WEpc = 1 regardless of stall, flush = 1, fetch_valid = 0.
  - taken_count increments, saturating at 0xFFFF.
  - Next state FETCH.
  - br_req and halt are ignored in COMPARE and REDIRECT.
- NOB1 holds its value until the next accepted br_req.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - ALUOp and ALU source-select constants (the parameter defaults);
  - PC_STEP = 2.
- No sub-module needed. Optionally factor the saturating counter as sat_counter16.

Test Plan:
- Reset then load_pc = 1 with inputPC1 = 0x0100 -> LOADPC for one cycle: inputPC = 1, WEpc = 1; back to IDLE, all outputs 0.
- start, 3 unstalled cycles -> fetch_valid = 1, WEpc = 1, ALUsrca = 1, ALUsrcb = 2 each cycle; assert stall for 2 cycles -> WEpc = 0, fetch_valid stays 1.
- br_req with br_jump = 0, br_op = 4'h5, target = 0x0040, then isTrue = 1 -> COMPARE (ALUOp = 5, WEpc = 0) then REDIRECT: NOB1 = 0x0040, normOrBranch = 1, flush = 1, taken_count = 1.
- Same request with isTrue = 0 -> COMPARE then FETCH; no flush, taken_count unchanged.
- br_req held while stall = 1 for 3 cycles -> no latch, NOB1 unchanged; accepted on the first stall = 0 cycle. br_jump = 1 -> REDIRECT directly next cycle.
- Force taken_count to 0xFFFF and take one more branch -> count stays 0xFFFF. Assert reset during REDIRECT -> next cycle IDLE, all outputs 0, NOB1 = 0.
